pwm_fade_sequencer: RTL

Drives the `pwm` stage from directly upstream, supplying everything on its control side. It generates the `enable` tick that advances the PWM period counter. It also produces the `compare_load` / `compare_value` pair that sets per-period duty, stepping brightness through fade-up/fade-down, ramp or fixed-level patterns. It keeps a shadow copy of the 7-bit PWM period counter so new duty values take effect exactly at a period boundary.

---
 rtl/pwm_fade_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pwm_fade_sequencer.sv
// rtl/pwm_fade_sequencer.sv - control-side sequencer for a 128-tick PWM stage
//
// Purpose: produces the PWM tick enable, the per-period compare load strobe
// and the 4-bit duty level. The level steps through triangle fade, sawtooth
// ramp or fixed-level patterns. A shadow copy of the downstream 7-bit period
// counter makes new levels land exactly on a period boundary.
//
// Ports:
//   clk_i            system clock
//   reset_i          synchronous, active-high reset
//   run_i            1 = sequencing advances, 0 = level and step count frozen
//   mode_i           00 hold, 01 triangle, 10 sawtooth, 11 fixed level
//   fixed_level_i    level used in mode 11, clamped to MAX_LEVEL
//   pwm_tick_o       one-cycle strobe every PRESCALE clocks
//   compare_load_o   one-cycle strobe on the last tick of each PWM period
//   compare_value_o  current brightness level
//   peak_o           one-cycle pulse after the level is written to MAX_LEVEL
module pwm_fade_sequencer #(
  parameter int unsigned PRESCALE     = 391,
  parameter int unsigned STEP_PERIODS = 4,
  parameter int unsigned MAX_LEVEL    = 10
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       run_i,
  input  logic [1:0] mode_i,
  input  logic [3:0] fixed_level_i,
  output logic       pwm_tick_o,
  output logic       compare_load_o,
  output logic [3:0] compare_value_o,
  output logic       peak_o
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  SCNT_LAST  = 8'(STEP_PERIODS - 1);
  localparam logic [3:0]  LVL_MAX    = 4'(MAX_LEVEL);
  localparam logic [6:0]  SPER_PRE   = 7'd126;
  localparam logic [6:0]  SPER_LAST  = 7'd127;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_TRI   = 2'b01;
  localparam logic [1:0] MODE_FIXED = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_FIXED
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [6:0]  sper_q,  sper_d;
  logic [7:0]  scnt_q,  scnt_d;
  logic [3:0]  lvl_q,   lvl_d;
  logic        peak_q,  peak_d;

  logic       tick;
  logic       pre;
  logic       active;
  logic       advance;
  logic       step_due;
  logic [3:0] fixed_clamped;

  // Tick and boundary strobes are decoded from registered counters only.
  assign tick = (presc_q == PRESC_LAST);
  // One tick before the boundary: updating here gives the level a full
  // tick of settling before the downstream stage loads it.
  assign pre  = tick && (sper_q == SPER_PRE);

  assign pwm_tick_o      = tick;
  assign compare_load_o  = tick && (sper_q == SPER_LAST);
  assign compare_value_o = lvl_q;
  assign peak_o          = peak_q;

  assign active        = run_i && (mode_i != MODE_HOLD);
  assign advance       = pre && active;
  assign step_due      = advance && (scnt_q == SCNT_LAST);
  assign fixed_clamped = (fixed_level_i > LVL_MAX) ? LVL_MAX : fixed_level_i;

  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    sper_d  = tick ? sper_q + 7'd1 : sper_q;

    scnt_d = scnt_q;
    if (advance) begin
      scnt_d = step_due ? 8'd0 : scnt_q + 8'd1;
    end

    state_d = state_q;
    lvl_d   = lvl_q;
    unique case (state_q)
      S_IDLE: begin
        // IDLE exit is not tied to the period boundary; the first level
        // change still waits for a step-due boundary.
        lvl_d = 4'd0;
        if (active) begin
          state_d = (mode_i == MODE_FIXED) ? S_FIXED : S_UP;
        end
      end
      S_FIXED: begin
        // Fixed level refreshes every period regardless of STEP_PERIODS;
        // leaving for a fade waits for a step-due boundary.
        if (advance) begin
          if (mode_i == MODE_FIXED) begin
            lvl_d = fixed_clamped;
          end else if (step_due) begin
            state_d = S_UP;
          end
        end
      end
      S_UP: begin
        if (step_due) begin
          if (mode_i == MODE_FIXED) begin
            state_d = S_FIXED;
          end else if (lvl_q < LVL_MAX) begin
            lvl_d = lvl_q + 4'd1;
          end else if (mode_i == MODE_TRI) begin
            state_d = S_DOWN;
            lvl_d   = LVL_MAX - 4'd1;
          end else begin
            lvl_d = 4'd0;
          end
        end
      end
      S_DOWN: begin
        if (step_due) begin
          if (mode_i == MODE_FIXED) begin
            state_d = S_FIXED;
          end else if (lvl_q != 4'd0) begin
            lvl_d = lvl_q - 4'd1;
          end else begin
            state_d = S_UP;
            lvl_d   = 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        lvl_d   = 4'd0;
      end
    endcase

    // Only a transition into MAX_LEVEL counts; re-writing the same value
    // (fixed mode) does not re-fire the pulse.
    peak_d = (lvl_d == LVL_MAX) && (lvl_q != LVL_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      presc_q <= 16'd0;
      sper_q  <= 7'd0;
      scnt_q  <= 8'd0;
      lvl_q   <= 4'd0;
      peak_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sper_q  <= sper_d;
      scnt_q  <= scnt_d;
      lvl_q   <= lvl_d;
      peak_q  <= peak_d;
    end
  end

endmodule
